// File: rtl/cacode_ctrl_if.sv
// Handshake and control bundle between a C/A code controller and its host.
// The host drives the master side; the controller implements the slave side.
interface cacode_ctrl_if #(
  parameter int NCO_W = 32
);
  logic             en;
  logic [NCO_W-1:0] code_rate;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [9:0]       cfg_g1_init;
  logic [9:0]       cfg_g2_init;
  logic [3:0]       cfg_t0;
  logic [3:0]       cfg_t1;
  logic             slew_valid;
  logic             slew_ready;
  logic [10:0]      slew_chips;
  logic [9:0]       g1_init;
  logic [9:0]       g2_init;
  logic [3:0]       t0;
  logic [3:0]       t1;
  logic             code_load;
  logic             code_step;
  logic [9:0]       chip_cnt;
  logic             epoch;
  logic [15:0]      epoch_cnt;

  modport master (
    output en, code_rate, cfg_valid, cfg_g1_init, cfg_g2_init, cfg_t0, cfg_t1,
           slew_valid, slew_chips,
    input  cfg_ready, slew_ready, g1_init, g2_init, t0, t1,
           code_load, code_step, chip_cnt, epoch, epoch_cnt
  );

  modport slave (
    input  en, code_rate, cfg_valid, cfg_g1_init, cfg_g2_init, cfg_t0, cfg_t1,
           slew_valid, slew_chips,
    output cfg_ready, slew_ready, g1_init, g2_init, t0, t1,
           code_load, code_step, chip_cnt, epoch, epoch_cnt
  );
endinterface

// File: rtl/cacode_ctrl.sv
// C/A code chip-rate controller: NCO-driven step strobes, chip/epoch counting,
// configuration loading and code-phase slewing for one tracking channel.
module cacode_ctrl #(
  parameter int NCO_W = 32
) (
  input logic         clk,
  input logic         rst,
  cacode_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, SLEW} state_t;

  state_t           state_reg;
  logic [NCO_W-1:0] acc_reg;
  logic [10:0]      remaining_reg;
  logic [9:0]       chip_reg;
  logic [15:0]      epoch_cnt_reg;
  logic             load_reg;
  logic             step_reg;
  logic             epoch_reg;
  logic [9:0]       g1_reg;
  logic [9:0]       g2_reg;
  logic [3:0]       t0_reg;
  logic [3:0]       t1_reg;

  logic             cfg_ready;
  logic             slew_ready;
  logic             cfg_take;
  logic             slew_take;
  logic [NCO_W:0]   sum_full;
  logic             carry;
  logic             chip_wrap;

  always_comb begin
    cfg_ready  = !rst && (state_reg != LOAD);
    cfg_take   = cfg_ready && bus.cfg_valid && bus.en;
    // Slew yields to a same-cycle configuration offer.
    slew_ready = !rst && bus.en && (state_reg == RUN) && !bus.cfg_valid;
    slew_take  = slew_ready && bus.slew_valid;
    sum_full   = {1'b0, acc_reg} + {1'b0, bus.code_rate};
    carry      = sum_full[NCO_W];
    chip_wrap  = (chip_reg == 10'd1022);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      remaining_reg <= '0;
      chip_reg      <= '0;
      epoch_cnt_reg <= '0;
      load_reg      <= 1'b0;
      step_reg      <= 1'b0;
      epoch_reg     <= 1'b0;
      g1_reg        <= 10'h3FF;
      g2_reg        <= 10'h3FF;
      t0_reg        <= '0;
      t1_reg        <= '0;
    end else begin
      load_reg  <= 1'b0;
      step_reg  <= 1'b0;
      epoch_reg <= 1'b0;
      if (!bus.en) begin
        state_reg     <= IDLE;
        remaining_reg <= '0;
      end else if (cfg_take) begin
        g1_reg        <= bus.cfg_g1_init;
        g2_reg        <= bus.cfg_g2_init;
        t0_reg        <= bus.cfg_t0;
        t1_reg        <= bus.cfg_t1;
        acc_reg       <= '0;
        chip_reg      <= '0;
        epoch_cnt_reg <= '0;
        remaining_reg <= '0;
        load_reg      <= 1'b1;
        state_reg     <= LOAD;
      end else begin
        case (state_reg)
          IDLE: state_reg <= IDLE;
          LOAD: state_reg <= RUN;
          RUN: begin
            acc_reg <= sum_full[NCO_W-1:0];
            if (carry) begin
              // Epoch stands in for the wrapping step so the strobes stay exclusive.
              if (chip_wrap) begin
                chip_reg      <= '0;
                epoch_reg     <= 1'b1;
                epoch_cnt_reg <= epoch_cnt_reg + 16'd1;
              end else begin
                chip_reg <= chip_reg + 10'd1;
                step_reg <= 1'b1;
              end
            end
            if (slew_take && (bus.slew_chips != 11'd0)) begin
              remaining_reg <= bus.slew_chips;
              state_reg     <= SLEW;
            end
          end
          SLEW: begin
            acc_reg <= sum_full[NCO_W-1:0];
            if (carry) begin
              remaining_reg <= remaining_reg - 11'd1;
              if (remaining_reg == 11'd1) begin
                state_reg <= RUN;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.cfg_ready  = cfg_ready;
  assign bus.slew_ready = slew_ready;
  assign bus.g1_init    = g1_reg;
  assign bus.g2_init    = g2_reg;
  assign bus.t0         = t0_reg;
  assign bus.t1         = t1_reg;
  assign bus.code_load  = load_reg;
  assign bus.code_step  = step_reg;
  assign bus.chip_cnt   = chip_reg;
  assign bus.epoch      = epoch_reg;
  assign bus.epoch_cnt  = epoch_cnt_reg;
endmodule

// File: tb/tb_cacode_ctrl.sv
// Randomized and directed bench for cacode_ctrl against a cycle-level
// behavioural model of the channel (mode flags, integer counters, wide-sum carry).
module tb_cacode_ctrl;
  localparam int NCO_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacode_ctrl_if #(.NCO_W(NCO_W)) bus ();

  cacode_ctrl #(.NCO_W(NCO_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // stimulus held by the bench, applied once per cycle
  bit          i_rst, i_en, i_cv, i_sv;
  logic [31:0] i_rate;
  logic [9:0]  i_g1, i_g2;
  logic [3:0]  i_t0, i_t1;
  logic [10:0] i_sc;

  // reference model
  bit     m_known, m_loading, m_active;
  int     m_slew, m_chip, m_ecnt;
  longint m_acc;
  bit     m_load, m_step, m_epoch;
  int     m_g1, m_g2, m_t0, m_t1;

  int  n_vec = 0;
  int  n_bad = 0;
  bit  seen_epoch;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    longint two_w;
    longint s;
    two_w = longint'(1) << NCO_W;
    m_load = 0; m_step = 0; m_epoch = 0;
    if (i_rst) begin
      m_known = 1; m_loading = 0; m_active = 0; m_slew = 0;
      m_acc = 0; m_chip = 0; m_ecnt = 0;
      m_g1 = 10'h3FF; m_g2 = 10'h3FF; m_t0 = 0; m_t1 = 0;
    end else if (!i_en) begin
      m_loading = 0; m_active = 0; m_slew = 0;
    end else if (i_cv && !m_loading) begin
      m_g1 = i_g1; m_g2 = i_g2; m_t0 = i_t0; m_t1 = i_t1;
      m_loading = 1; m_active = 0; m_slew = 0;
      m_acc = 0; m_chip = 0; m_ecnt = 0; m_load = 1;
    end else if (m_loading) begin
      m_loading = 0; m_active = 1;
    end else if (m_active) begin
      s = m_acc + longint'(i_rate);
      m_acc = s % two_w;
      if (m_slew > 0) begin
        if (s >= two_w) m_slew--;
      end else begin
        if (s >= two_w) begin
          if (m_chip == 1022) begin
            m_chip = 0; m_epoch = 1; m_ecnt = (m_ecnt + 1) % 65536;
          end else begin
            m_chip++; m_step = 1;
          end
        end
        if (i_sv) m_slew = i_sc;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    rst             = i_rst;
    bus.en          = i_en;
    bus.code_rate   = i_rate;
    bus.cfg_valid   = i_cv;
    bus.cfg_g1_init = i_g1;
    bus.cfg_g2_init = i_g2;
    bus.cfg_t0      = i_t0;
    bus.cfg_t1      = i_t1;
    bus.slew_valid  = i_sv;
    bus.slew_chips  = i_sc;
    #1;
    check("cfg_ready", 64'(bus.cfg_ready), 64'(!i_rst && !m_loading));
    check("slew_ready", 64'(bus.slew_ready),
          64'(!i_rst && i_en && m_active && m_slew == 0 && !i_cv));
    seen_epoch = bus.epoch;
    if (m_known) begin
      check("code_load", 64'(bus.code_load), 64'(m_load));
      check("code_step", 64'(bus.code_step), 64'(m_step));
      check("epoch", 64'(bus.epoch), 64'(m_epoch));
      check("chip_cnt", 64'(bus.chip_cnt), 64'(m_chip));
      check("epoch_cnt", 64'(bus.epoch_cnt), 64'(m_ecnt));
      check("g1_init", 64'(bus.g1_init), 64'(m_g1));
      check("g2_init", 64'(bus.g2_init), 64'(m_g2));
      check("t0", 64'(bus.t0), 64'(m_t0));
      check("t1", 64'(bus.t1), 64'(m_t1));
    end
    @(posedge clk);
    model_step();
  endtask

  task automatic offer_cfg(input logic [9:0] g1, input logic [9:0] g2,
                           input logic [3:0] t0, input logic [3:0] t1);
    i_cv = 1; i_g1 = g1; i_g2 = g2; i_t0 = t0; i_t1 = t1;
    cycle();
    i_cv = 0;
  endtask

  int lat;
  int ep_before;

  initial begin
    m_known = 0; m_loading = 0; m_active = 0; m_slew = 0;
    i_rst = 1; i_en = 0; i_cv = 0; i_sv = 0; i_rate = '0;
    i_g1 = '0; i_g2 = '0; i_t0 = '0; i_t1 = '0; i_sc = '0;
    repeat (3) cycle();
    i_rst = 0;
    cycle();

    // half-rate run: first epoch 2046 cycles after the first RUN cycle
    i_en = 1; i_rate = 32'h8000_0000;
    offer_cfg(10'h3FF, 10'h3FF, 4'd2, 4'd6);
    cycle();
    lat = 0;
    do begin
      cycle();
      lat++;
    end while (!seen_epoch && lat < 3000);
    check("epoch_latency_from_load", 64'(lat), 64'd2047);

    // 5-chip slew, then slew offered together with cfg
    i_sv = 1; i_sc = 11'd5; cycle(); i_sv = 0;
    repeat (30) cycle();
    i_sv = 1; i_sc = 11'd5;
    offer_cfg(10'h155, 10'h2AA, 4'd3, 4'd9);
    i_sv = 0;
    repeat (5) cycle();

    // near-full-scale rate: two epochs in about 2046 cycles
    i_rate = 32'hFFFF_FFFF;
    ep_before = m_ecnt;
    repeat (2060) cycle();
    check("epoch_cnt_fast", 64'(bus.epoch_cnt), 64'(ep_before + 2));

    // enable dropped mid-run, then returned without cfg
    i_rate = 32'h8000_0000;
    i_en = 0; repeat (20) cycle();
    i_en = 1; repeat (10) cycle();
    offer_cfg(10'h3FF, 10'h3FF, 4'd1, 4'd5);
    repeat (20) cycle();

    // reset during a slew, and a zero-chip slew no-op
    i_sv = 1; i_sc = 11'd0; cycle();
    i_sc = 11'd50; cycle(); i_sv = 0;
    repeat (6) cycle();
    i_rst = 1; cycle(); i_rst = 0;
    repeat (5) cycle();

    // randomized traffic
    for (int n = 0; n < 15000; n++) begin
      if (n % 500 == 0) begin
        case ($urandom_range(0, 4))
          0: i_rate = 32'h0;
          1: i_rate = 32'h8000_0000;
          2: i_rate = 32'hFFFF_FFFF;
          3: i_rate = 32'h4000_0000;
          default: i_rate = $urandom;
        endcase
      end
      i_rst = ($urandom_range(0, 999) == 0);
      i_en  = ($urandom_range(0, 99) != 0);
      i_cv  = ($urandom_range(0, 199) == 0);
      i_g1  = 10'($urandom); i_g2 = 10'($urandom);
      i_t0  = 4'($urandom);  i_t1 = 4'($urandom);
      i_sv  = ($urandom_range(0, 19) == 0);
      i_sc  = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 12));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/cacode_ctrl.md
CACODE_CTRL -- requirements
Module: cacode_ctrl

Interface
REQ-001 Parameter NCO_W, default 32, code NCO accumulator and rate width.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 en  in  1  channel enable; low forces IDLE.
REQ-005 code_rate  in  NCO_W  chip-rate NCO increment per clk.
REQ-006 cfg_valid  in  1  new code configuration offered.
REQ-007 cfg_ready  out  1  configuration can be accepted this cycle.
REQ-008 cfg_g1_init, cfg_g2_init  in  10 each  generator preset words.
REQ-009 cfg_t0, cfg_t1  in  4 each  G2 phase-selector taps.
REQ-010 slew_valid  in  1  code-phase slew request.
REQ-011 slew_ready  out  1  slew request can be accepted this cycle.
REQ-012 slew_chips  in  11  chips to delay the code phase by.
REQ-013 g1_init, g2_init, t0, t1  out  10/10/4/4  registered config to the code generator.
REQ-014 code_load  out  1  one-cycle preset strobe to the code generator.
REQ-015 code_step  out  1  one-cycle advance-one-chip strobe to the code generator.
REQ-016 chip_cnt  out  10  current chip index, 0..1022.
REQ-017 epoch  out  1  one-cycle pulse on code-period wrap.
REQ-018 epoch_cnt  out  16  epochs since last load, wraps modulo 2^16.

Function
REQ-019 States IDLE, LOAD, RUN and SLEW, encoded as one registered state variable.
REQ-020 cfg_ready SHALL be 1 in IDLE, RUN and SLEW, and 0 in LOAD.
REQ-021 cfg accepted when cfg_valid&cfg_ready&en; capture the cfg_* fields into g1_init/g2_init/t0/t1 and go to LOAD next cycle.
REQ-022 LOAD lasts exactly one cycle: code_load=1; chip_cnt, nco_acc, epoch_cnt cleared to 0; next state RUN.
REQ-023 RUN: each cycle nco_acc <= nco_acc + code_rate modulo 2^NCO_W.
REQ-024 RUN: carry out of that add SHALL assert code_step in the same cycle the wrapped acc is registered.
REQ-025 On each code_step, chip_cnt increments; at 1022 it wraps to 0 with epoch=1 and epoch_cnt+1 in the same cycle.
REQ-026 slew_ready=1 only in RUN with no cfg acceptance in the same cycle; cfg acceptance takes priority over slew.
REQ-027 Slew accepted with slew_chips=0 is a no-op and state stays RUN.
REQ-028 Slew accepted with slew_chips=N (1..2047) loads remaining=N and enters SLEW next cycle.
REQ-029 SLEW: NCO keeps accumulating; each carry decrements remaining, code_step=0, and chip_cnt/epoch unchanged.
REQ-030 SLEW: the carry that takes remaining to 0 returns to RUN; the next carry steps normally.
REQ-031 cfg accepted during SLEW aborts the slew and goes to LOAD.
REQ-032 en=0 in any state: next state IDLE, with code_step, code_load and epoch forced 0 in that cycle.
REQ-033 en=0: nco_acc and chip_cnt hold their values.
REQ-034 en reasserted from IDLE with no cfg: state stays IDLE; RUN is reached only via LOAD.
REQ-035 code_step, code_load and epoch are mutually exclusive, and each is a single-cycle pulse.
REQ-036 code_rate=0 in RUN: no steps are generated, and this is a legal stall.

Reset
REQ-037 rst SHALL override all inputs, including en and cfg_valid.
REQ-038 rst clears state to IDLE; code_load, code_step and epoch to 0; chip_cnt, epoch_cnt, nco_acc and remaining to 0.
REQ-039 rst sets g1_init and g2_init to 10'h3FF, and t0 and t1 to 0.
REQ-040 rst mid-LOAD or mid-SLEW SHALL discard the operation in progress.
REQ-041 cfg_ready=0 and slew_ready=0 while rst is high.

Verification
REQ-042 Load cfg g1=3FF, g2=3FF, t0=2, t1=6, en=1, then rate=2^31 -> code_load one cycle; code_step every 2nd cycle; first epoch 2046 cycles after the first RUN cycle; chip_cnt=0 at epoch.
REQ-043 rate=2^NCO_W-1 -> code_step on every cycle except one per 2^NCO_W cycles; epoch_cnt reaches 2 after about 2046 cycles.
REQ-044 rate=2^31 in RUN, slew_chips=5 -> no code_step for 10 cycles; chip_cnt frozen; then steps resume.
REQ-045 slew_chips=5 with a cfg_valid in the same cycle -> slew_ready=0, LOAD taken, chip_cnt=0.
REQ-046 Drop en mid-RUN for 20 cycles -> no strobes and acc held; IDLE persists after en returns until a new cfg.
REQ-047 Assert rst during SLEW -> next cycle IDLE with all outputs at their REQ-038/REQ-039 values; no stray code_step.
